// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : Moore-style control FSM for a multicycle MIPS-subset core
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  instrn_opcode,
    input  logic        zero_out,
    input  logic        mem_ready,
    output logic        mem_rd_req,
    output logic        ctrl_datamem_write_en,
    output logic        ir_write_en,
    output logic        pc_write_en,
    output logic        ctrl_pc_src,
    output logic        ctrl_write_en,
    output logic        ctrl_regdst,
    output logic        ctrl_memtoreg,
    output logic        ctrl_alusrc,
    output logic        illegal_op,
    output logic [2:0]  state,
    output logic [15:0] retired_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            case (state_q)
                FETCH:  if (mem_ready) state_q <= DECODE;
                DECODE: state_q <= EXEC;
                EXEC: begin
                    case (instrn_opcode)
                        OP_RTYPE:     state_q <= WB;
                        OP_LW, OP_SW: state_q <= MEM;
                        OP_BEQ: begin
                            state_q <= FETCH;
                            count_q <= count_q + 16'd1;
                        end
                        default:      state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        if (instrn_opcode == OP_SW) begin
                            state_q <= FETCH;
                            count_q <= count_q + 16'd1;
                        end else begin
                            state_q <= WB;
                        end
                    end
                end
                WB: begin
                    state_q <= FETCH;
                    count_q <= count_q + 16'd1;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Strobes are decoded from the registered state; the handshake strobes
    // must act in the same cycle as mem_ready/zero_out, and rst_n masks them
    // so nothing is requested while reset is held.
    always_comb begin
        mem_rd_req            = 1'b0;
        ctrl_datamem_write_en = 1'b0;
        ir_write_en           = 1'b0;
        pc_write_en           = 1'b0;
        ctrl_pc_src           = 1'b0;
        ctrl_write_en         = 1'b0;
        ctrl_regdst           = 1'b0;
        ctrl_memtoreg         = 1'b0;
        ctrl_alusrc           = 1'b0;
        illegal_op            = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_rd_req  = 1'b1;
                    ir_write_en = mem_ready;
                    pc_write_en = mem_ready;
                end
                EXEC: begin
                    ctrl_alusrc = (instrn_opcode == OP_LW) || (instrn_opcode == OP_SW);
                    case (instrn_opcode)
                        OP_RTYPE, OP_LW, OP_SW: ;
                        OP_BEQ: begin
                            pc_write_en = zero_out;
                            ctrl_pc_src = zero_out;
                        end
                        default: illegal_op = 1'b1;
                    endcase
                end
                MEM: begin
                    if (instrn_opcode == OP_SW) ctrl_datamem_write_en = 1'b1;
                    else                        mem_rd_req            = 1'b1;
                end
                WB: begin
                    ctrl_write_en = 1'b1;
                    ctrl_regdst   = (instrn_opcode == OP_RTYPE);
                    ctrl_memtoreg = (instrn_opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign state         = state_q;
    assign retired_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : randomized instruction-level check of multicycle_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  instrn_opcode;
    logic        zero_out;
    logic        mem_ready;
    logic        mem_rd_req, ctrl_datamem_write_en, ir_write_en, pc_write_en;
    logic        ctrl_pc_src, ctrl_write_en, ctrl_regdst, ctrl_memtoreg;
    logic        ctrl_alusrc, illegal_op;
    logic [2:0]  state;
    logic [15:0] retired_count;

    multicycle_ctrl dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .instrn_opcode         (instrn_opcode),
        .zero_out              (zero_out),
        .mem_ready             (mem_ready),
        .mem_rd_req            (mem_rd_req),
        .ctrl_datamem_write_en (ctrl_datamem_write_en),
        .ir_write_en           (ir_write_en),
        .pc_write_en           (pc_write_en),
        .ctrl_pc_src           (ctrl_pc_src),
        .ctrl_write_en         (ctrl_write_en),
        .ctrl_regdst           (ctrl_regdst),
        .ctrl_memtoreg         (ctrl_memtoreg),
        .ctrl_alusrc           (ctrl_alusrc),
        .illegal_op            (illegal_op),
        .state                 (state),
        .retired_count         (retired_count)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: state, inputs to apply, and strobe vector
    // {rd, dmw, irw, pcw, pcsrc, we, regdst, memtoreg, alusrc, illegal}.
    typedef struct packed {
        logic [2:0] st;
        logic       rdy;
        logic       zero;
        logic [9:0] outs;
    } cyc_t;

    cyc_t        trace[$];
    logic        trace_retires;
    logic [15:0] model_count;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [9:0] observed_outs();
        return {mem_rd_req, ctrl_datamem_write_en, ir_write_en, pc_write_en,
                ctrl_pc_src, ctrl_write_en, ctrl_regdst, ctrl_memtoreg,
                ctrl_alusrc, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic add(input logic [2:0] st, input logic rdy, input logic zero, input logic [9:0] outs);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.zero = zero; c.outs = outs;
        trace.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction from the ISA rules.
    task automatic build(input logic [5:0] op, input logic zero, input int fwait, input int mwait);
        logic is_r, is_lw, is_sw, is_beq, legal;
        is_r   = (op == 6'h00);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_beq = (op == 6'h04);
        legal  = is_r | is_lw | is_sw | is_beq;
        trace.delete();
        for (int i = 0; i < fwait; i++) add(3'd0, 1'b0, rbit(), 10'b10_0000_0000);
        add(3'd0, 1'b1, rbit(), 10'b10_1100_0000);
        add(3'd1, rbit(), rbit(), 10'b0);
        add(3'd2, rbit(), is_beq ? zero : rbit(),
            {3'b000, is_beq & zero, is_beq & zero, 3'b000, is_lw | is_sw, ~legal});
        if (is_lw || is_sw) begin
            for (int i = 0; i < mwait; i++) add(3'd3, 1'b0, rbit(), {is_lw, is_sw, 8'b0});
            add(3'd3, 1'b1, rbit(), {is_lw, is_sw, 8'b0});
        end
        if (is_r || is_lw) add(3'd4, rbit(), rbit(), {5'b0, 1'b1, is_r, is_lw, 2'b00});
        trace_retires = legal;
    endtask

    // Plays the trace; abort_at >= 0 asserts reset mid-cycle at that index.
    task automatic play(input string name, input logic [5:0] op, input int abort_at);
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clk);
            instrn_opcode = (trace[i].st == 3'd0) ? 6'($urandom) : op;
            mem_ready     = trace[i].rdy;
            zero_out      = trace[i].zero;
            #1;
            check($sformatf("%s c%0d state/strobes", name, i),
                  32'({state, observed_outs()}), 32'({trace[i].st, trace[i].outs}));
            check($sformatf("%s c%0d retired", name, i),
                  32'(retired_count), 32'(model_count));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                model_count = 16'd0;
                check($sformatf("%s reset state/strobes", name),
                      32'({state, observed_outs()}), 32'd0);
                check($sformatf("%s reset retired", name),
                      32'(retired_count), 32'(model_count));
                @(negedge clk);
                mem_ready = 1'b0;
                rst_n     = 1'b1;
                return;
            end
        end
        if (trace_retires) model_count = model_count + 16'd1;
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic zero,
                       input int fwait, input int mwait);
        build(op, zero, fwait, mwait);
        play(name, op, -1);
    endtask

    initial begin
        logic [5:0] op;
        rst_n         = 1'b0;
        instrn_opcode = 6'h00;
        zero_out      = 1'b0;
        mem_ready     = 1'b1;
        model_count   = 16'd0;
        #12;
        check("reset state/strobes", 32'({state, observed_outs()}), 32'd0);
        check("reset retired", 32'(retired_count), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        run("rtype",     6'h00, 1'b0, 0, 0);
        run("lw_wait2",  6'h23, 1'b0, 0, 2);
        run("beq_taken", 6'h04, 1'b1, 0, 0);
        run("beq_not",   6'h04, 1'b0, 0, 0);
        run("illegal3f", 6'h3F, 1'b0, 0, 0);
        run("sw_fwait",  6'h2B, 1'b0, 2, 1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: begin
                    do op = 6'($urandom);
                    while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04);
                end
            endcase
            run($sformatf("rnd%0d_op%0h", n, op), op, rbit(),
                $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset lands on the first MEM stall cycle of a store.
        build(6'h2B, 1'b0, 0, 2);
        play("sw_abort", 6'h2B, 3);
        run("post_abort", 6'h00, 1'b0, 0, 0);

        // Preload near the top of the range, then let R-types carry it over.
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        model_count = 16'hFFFE;
        for (int n = 0; n < 3; n++) run($sformatf("wrap%0d", n), 6'h00, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        check("wrap final retired", 32'(retired_count), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port instrn_opcode, input, 6 bits: opcode of the instruction held in the instruction register.
REQ-004 SHALL have port zero_out, input, 1 bit: ALU zero flag, valid in EXEC.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current request in this cycle.
REQ-006 SHALL have port mem_rd_req, output, 1 bit: memory read request, instruction or data.
REQ-007 SHALL have port ctrl_datamem_write_en, output, 1 bit: data memory write request.
REQ-008 SHALL have port ir_write_en, output, 1 bit: load the instruction register.
REQ-009 SHALL have port pc_write_en, output, 1 bit: load the PC.
REQ-010 SHALL have port ctrl_pc_src, output, 1 bit: PC source select, 0 = PC+4, 1 = branch_address.
REQ-011 SHALL have port ctrl_write_en, output, 1 bit: register file write.
REQ-012 SHALL have port ctrl_regdst, output, 1 bit: write address select, 1 = instrn[15:11], 0 = instrn[20:16].
REQ-013 SHALL have port ctrl_memtoreg, output, 1 bit: write data select, 1 = datamem_read_data, 0 = alu_result.
REQ-014 SHALL have port ctrl_alusrc, output, 1 bit: ALU input 2 select, 1 = sign_ext_out, 0 = read_data2.
REQ-015 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-016 SHALL have port state, output, 3 bits: current FSM state.
REQ-017 SHALL have port retired_count, output, 16 bits: count of completed instructions.

Function
REQ-018 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL return to FETCH on the next edge.
REQ-019 FETCH SHALL hold mem_rd_req=1 and stay in FETCH while mem_ready=0.
REQ-020 FETCH with mem_ready=1 SHALL pulse ir_write_en=1 and pc_write_en=1 with ctrl_pc_src=0, then go to DECODE.
REQ-021 DECODE SHALL always go to EXEC after one cycle.
REQ-022 EXEC SHALL take the transition set by the opcode.
- 0x00 (R-type): go to WB.
- 0x23 (lw) and 0x2B (sw): go to MEM.
- 0x04 (beq): go to FETCH; if zero_out=1, assert pc_write_en=1 with ctrl_pc_src=1.
- Any other opcode: pulse illegal_op and go to FETCH.
REQ-023 In EXEC, ctrl_alusrc SHALL be 1 for opcodes 0x23 and 0x2B and 0 otherwise.
REQ-024 MEM for lw SHALL assert mem_rd_req and go to WB only when mem_ready=1.
REQ-025 MEM for sw SHALL assert ctrl_datamem_write_en and go to FETCH only when mem_ready=1.
REQ-026 WB SHALL assert ctrl_write_en=1 for exactly one cycle, then go to FETCH.
- R-type: ctrl_regdst=1, ctrl_memtoreg=0.
- lw: ctrl_regdst=0, ctrl_memtoreg=1.
REQ-027 retired_count SHALL increment by 1 on leaving WB, on completing MEM for sw, and on leaving EXEC for beq.
REQ-028 retired_count SHALL NOT increment for an illegal opcode.
REQ-029 retired_count SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-030 When all memory accesses complete with no wait, latency SHALL be 4 cycles for R-type, 5 for lw, 4 for sw, 3 for beq.
REQ-031 Each mem_ready=0 cycle in FETCH or MEM SHALL add exactly one cycle to latency.
REQ-032 All outputs not named active in the current state SHALL be 0.
REQ-033 mem_ready sampled in DECODE, EXEC or WB SHALL be ignored.
REQ-034 instrn_opcode SHALL be sampled only in EXEC, MEM and WB, and SHALL be stable from DECODE through the end of the instruction.

Reset
REQ-035 rst_n=0 SHALL immediately force state=FETCH, retired_count=0 and every strobe output to 0, regardless of clk.
REQ-036 Reset asserted mid-instruction, including with a memory request outstanding, SHALL abandon the instruction without a register or memory write.
REQ-037 After rst_n deasserts, the first rising edge SHALL evaluate FETCH.

Verification
REQ-038 R-type, mem_ready tied to 1: opcode 0x00 -> states 0,1,2,4 then 0; ctrl_write_en=1 and ctrl_regdst=1 in cycle 4 only; retired_count=1.
REQ-039 lw with 2 wait cycles in MEM: opcode 0x23, mem_ready low for 2 cycles -> MEM lasts 3 cycles with mem_rd_req=1; WB has ctrl_memtoreg=1 and ctrl_regdst=0; total 7 cycles.
REQ-040 beq taken and not taken: opcode 0x04 with zero_out=1 -> in EXEC, pc_write_en=1 and ctrl_pc_src=1; with zero_out=0 -> pc_write_en=0; each case takes 3 cycles and adds 1 to retired_count.
REQ-041 Illegal opcode: opcode 0x3F -> illegal_op=1 for 1 cycle in EXEC; no ctrl_write_en and no ctrl_datamem_write_en; retired_count unchanged.
REQ-042 Reset during a sw stall: rst_n=0 while in MEM with mem_ready=0 -> state=0 and ctrl_datamem_write_en=0 in the same cycle; retired_count=0.
REQ-043 Counter wrap: preload by running 65536 R-type instructions -> retired_count returns to 0x0000.
